uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// Button-driven byte sequencer: a debounced press queues the switch value, and
// queued bytes are handed one at a time to a UART transmitter with an ack timeout.
module uart_tx_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int ACK_TIMEOUT     = 8
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [2:0] switches,
    input  logic       send_btn,
    input  logic       tx_busy,
    input  logic       clear_err,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overflow_err,
    output logic       ack_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE     = DW'(1);
    localparam logic [TW-1:0] TO_LAST    = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE     = TW'(1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

    state_t          state_reg;
    logic [2:0]      sw_meta_reg, sw_sync_reg;
    logic            btn_meta_reg, btn_sync_reg;
    logic            btn_db_reg, btn_db_prev_reg;
    logic [DW-1:0]   db_cnt_reg;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [TW-1:0]   to_cnt_reg;
    logic            tx_start_reg;
    logic [7:0]      tx_data_reg;
    logic            overflow_err_reg, ack_err_reg;

    logic push, pop, push_ok, overflow_set, ack_timeout;

    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == FULL_COUNT);
    assign push         = btn_db_reg & ~btn_db_prev_reg;
    assign pop          = (state_reg == IDLE) && !fifo_empty && !tx_busy;
    // A simultaneous pop frees a slot, so a push into a full queue still lands.
    assign push_ok      = push && (!fifo_full || pop);
    assign overflow_set = push && fifo_full && !pop;
    assign ack_timeout  = (state_reg == WAIT_ACK) && !tx_busy && (to_cnt_reg == TO_LAST);

    assign tx_start     = tx_start_reg;
    assign tx_data      = tx_data_reg;
    assign overflow_err = overflow_err_reg;
    assign ack_err      = ack_err_reg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sw_meta_reg     <= '0;
            sw_sync_reg     <= '0;
            btn_meta_reg    <= 1'b0;
            btn_sync_reg    <= 1'b0;
            btn_db_reg      <= 1'b0;
            btn_db_prev_reg <= 1'b0;
            db_cnt_reg      <= '0;
        end else begin
            sw_meta_reg     <= switches;
            sw_sync_reg     <= sw_meta_reg;
            btn_meta_reg    <= send_btn;
            btn_sync_reg    <= btn_meta_reg;
            btn_db_prev_reg <= btn_db_reg;
            // Any return to the accepted level restarts the stability count.
            if (btn_sync_reg != btn_db_reg) begin
                if (db_cnt_reg == DB_LAST) begin
                    btn_db_reg <= btn_sync_reg;
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DB_ONE;
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= {5'b00000, sw_sync_reg};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg    <= IDLE;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            to_cnt_reg   <= '0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        tx_data_reg  <= mem[rd_ptr_reg];
                        tx_start_reg <= 1'b1;
                        state_reg    <= START;
                    end
                end
                START: begin
                    to_cnt_reg <= '0;
                    state_reg  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as a clear takes priority.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            overflow_err_reg <= 1'b0;
            ack_err_reg      <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_err_reg <= 1'b1;
            end else if (clear_err) begin
                overflow_err_reg <= 1'b0;
            end
            if (ack_timeout) begin
                ack_err_reg <= 1'b1;
            end else if (clear_err) begin
                ack_err_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: directed scenarios plus randomized
// bouncing presses scored against an expected byte queue and arithmetic latencies.
module tb_uart_tx_sequencer;
    localparam int N    = 16;
    localparam int DEPTH = 4;
    localparam int TMO  = 8;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [2:0] switches = 3'b000;
    logic       send_btn = 1'b0;
    logic       tx_busy = 1'b0;
    logic       clear_err = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       fifo_empty, fifo_full, overflow_err, ack_err;

    always #5 Clk = ~Clk;

    uart_tx_sequencer #(
        .DEBOUNCE_CYCLES(N),
        .FIFO_DEPTH(DEPTH),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .switches(switches),
        .send_btn(send_btn),
        .tx_busy(tx_busy),
        .clear_err(clear_err),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .overflow_err(overflow_err),
        .ack_err(ack_err)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] st_data[$];
    int         st_cyc[$];

    // Transmitter responder: raises busy resp_delay cycles after a start, for resp_len cycles.
    bit resp_on = 1'b0;
    int resp_delay = 2;
    int resp_len = 10;
    int wait_cnt = 0;
    int hold_cnt = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        if (tx_start === 1'b1) begin
            st_data.push_back(tx_data);
            st_cyc.push_back(cyc);
        end
        if (resp_on) begin
            if (tx_start === 1'b1) begin
                wait_cnt = resp_delay;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    tx_busy = 1'b1;
                    hold_cnt = resp_len;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) tx_busy = 1'b0;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clean_press(input logic [2:0] sw, input int hold, input int rel);
        switches = sw;
        send_btn = 1'b1;
        ticks(hold);
        send_btn = 1'b0;
        ticks(rel);
    endtask

    task automatic clear_log();
        st_data.delete();
        st_cyc.delete();
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        ticks(2);
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_fifo_empty: got %b want 1", fifo_empty); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_fifo_full: got %b want 0", fifo_full); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_overflow_err: got %b want 0", overflow_err); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        Rst_n = 1'b1;
        ticks(4);
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL idle_after_reset: fifo_empty got %b want 1", fifo_empty); end
        $display("test_reset done");
    endtask

    task automatic test_single_send();
        int n0;
        int t_empty;
        logic [7:0] held;
        clear_log();
        t_empty = -1;
        held = 8'hxx;
        resp_on = 1'b1; resp_delay = 2; resp_len = 10;
        switches = 3'b101;
        ticks(4);
        send_btn = 1'b1;
        n0 = cyc;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (t_empty < 0 && fifo_empty === 1'b0) t_empty = cyc - n0;
            if (cyc - n0 == N + 12) held = tx_data;
        end
        send_btn = 1'b0;
        ticks(40);
        total++; if (t_empty != N + 3) begin bad++; $display("FAIL push_latency: fifo_empty fell at %0d want %0d", t_empty, N + 3); end
        total++; if (st_data.size() != 1) begin bad++; $display("FAIL single_start_count: got %0d want 1", st_data.size()); end
        if (st_data.size() > 0) begin
            total++; if (st_cyc[0] - n0 != N + 4) begin bad++; $display("FAIL start_latency: got %0d want %0d", st_cyc[0] - n0, N + 4); end
            total++; if (st_data[0] !== 8'h05) begin bad++; $display("FAIL single_data: got %h want 05", st_data[0]); end
        end
        total++; if (held !== 8'h05) begin bad++; $display("FAIL data_held_busy: got %h want 05", held); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL single_empty_after: got %b want 1", fifo_empty); end
        $display("test_single_send: starts=%0d", st_data.size());
    endtask

    task automatic test_debounce();
        int n_rise;
        clear_log();
        resp_on = 1'b1; resp_delay = 2; resp_len = 5;
        switches = 3'b011;
        ticks(4);
        for (int i = 0; i < 30; i++) begin
            send_btn = ((i / 3) % 2 == 0);
            tick();
        end
        send_btn = 1'b1;
        n_rise = cyc;
        ticks(N + 30);
        send_btn = 1'b0;
        ticks(N + 8);
        total++; if (st_data.size() != 1) begin bad++; $display("FAIL debounce_push_count: got %0d want 1", st_data.size()); end
        if (st_data.size() > 0) begin
            total++; if (st_cyc[0] - n_rise != N + 4) begin bad++; $display("FAIL debounce_timing: got %0d want %0d", st_cyc[0] - n_rise, N + 4); end
            total++; if (st_data[0] !== 8'h03) begin bad++; $display("FAIL debounce_data: got %h want 03", st_data[0]); end
        end
        $display("test_debounce: starts=%0d", st_data.size());
    endtask

    task automatic test_overflow();
        int n0;
        logic ov_before, ov_at;
        clear_log();
        ov_before = 1'bx; ov_at = 1'bx;
        resp_on = 1'b0;
        tx_busy = 1'b1;
        ticks(2);
        for (int k = 1; k <= 5; k++) begin
            clean_press(3'(k), N + 6, N + 6);
            if (k == 3) begin
                total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL not_full_3: got %b want 0", fifo_full); end
            end
            if (k == 4) begin
                total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL full_4: got %b want 1", fifo_full); end
                total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL no_overflow_4: got %b want 0", overflow_err); end
            end
        end
        total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_5: got %b want 1", overflow_err); end
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL full_5: got %b want 1", fifo_full); end
        // Sixth press with clear held: the set edge must win, then clear takes it away.
        clear_err = 1'b1;
        switches = 3'd6;
        send_btn = 1'b1;
        n0 = cyc;
        for (int i = 0; i < N + 6; i++) begin
            tick();
            if (cyc - n0 == N + 2) ov_before = overflow_err;
            if (cyc - n0 == N + 3) ov_at = overflow_err;
        end
        send_btn = 1'b0;
        ticks(4);
        clear_err = 1'b0;
        tick();
        total++; if (ov_before !== 1'b0) begin bad++; $display("FAIL clear_applied: got %b want 0", ov_before); end
        total++; if (ov_at !== 1'b1) begin bad++; $display("FAIL set_beats_clear: got %b want 1", ov_at); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL overflow_cleared: got %b want 0", overflow_err); end
        tx_busy = 1'b0;
        resp_on = 1'b1; resp_delay = 3; resp_len = 4;
        ticks(150);
        total++; if (st_data.size() != 4) begin bad++; $display("FAIL drain_count: got %0d want 4", st_data.size()); end
        for (int i = 0; i < 4 && i < st_data.size(); i++) begin
            total++; if (st_data[i] !== 8'(i + 1)) begin bad++; $display("FAIL drain_order[%0d]: got %h want %h", i, st_data[i], 8'(i + 1)); end
        end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", fifo_empty); end
        $display("test_overflow: starts=%0d", st_data.size());
    endtask

    task automatic test_ack_timeout();
        logic [2:0] sw;
        logic a0, a1, before_clr;
        clear_log();
        a0 = 1'bx; a1 = 1'bx;
        resp_on = 1'b0;
        tx_busy = 1'b0;
        sw = 3'($urandom_range(0, 7));
        switches = sw;
        send_btn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == N + 6) send_btn = 1'b0;
            tick();
            if (st_cyc.size() > 0 && cyc - st_cyc[0] == TMO) a0 = ack_err;
            if (st_cyc.size() > 0 && cyc - st_cyc[0] == TMO + 1) a1 = ack_err;
        end
        before_clr = ack_err;
        total++; if (st_data.size() != 1) begin bad++; $display("FAIL timeout_no_retry: starts got %0d want 1", st_data.size()); end
        if (st_data.size() > 0) begin
            total++; if (st_data[0] !== {5'b0, sw}) begin bad++; $display("FAIL timeout_data: got %h want %h", st_data[0], {5'b0, sw}); end
        end
        total++; if (a0 !== 1'b0) begin bad++; $display("FAIL ack_err_early: got %b want 0", a0); end
        total++; if (a1 !== 1'b1) begin bad++; $display("FAIL ack_err_set: got %b want 1", a1); end
        total++; if (before_clr !== 1'b1) begin bad++; $display("FAIL ack_err_sticky: got %b want 1", before_clr); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL timeout_empty: got %b want 1", fifo_empty); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL ack_err_clear: got %b want 0", ack_err); end
        clear_log();
        resp_on = 1'b1; resp_delay = 2; resp_len = 3;
        clean_press(~sw, N + 6, N + 10);
        total++; if (st_data.size() != 1) begin bad++; $display("FAIL after_timeout_send: starts got %0d want 1", st_data.size()); end
        if (st_data.size() > 0) begin
            total++; if (st_data[0] !== {5'b0, ~sw}) begin bad++; $display("FAIL after_timeout_data: got %h want %h", st_data[0], {5'b0, ~sw}); end
        end
        $display("test_ack_timeout: byte=%h", {5'b0, sw});
    endtask

    task automatic test_reset_mid();
        clear_log();
        resp_on = 1'b0;
        tx_busy = 1'b0;
        switches = 3'd7;
        send_btn = 1'b1;
        for (int i = 0; i < N + 6; i++) begin
            tick();
            if (st_data.size() > 0) tx_busy = 1'b1;
        end
        send_btn = 1'b0;
        ticks(N + 6);
        clean_press(3'd1, N + 6, N + 6);
        clean_press(3'd2, N + 6, N + 6);
        total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL queued_before_reset: fifo_empty got %b want 0", fifo_empty); end
        total++; if (tx_data !== 8'h07) begin bad++; $display("FAIL inflight_data: got %h want 07", tx_data); end
        tick();
        #2 Rst_n = 1'b0;
        #1;
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL async_reset_data: got %h want 00", tx_data); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL async_reset_empty: got %b want 1", fifo_empty); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL async_reset_full: got %b want 0", fifo_full); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL async_reset_start: got %b want 0", tx_start); end
        ticks(3);
        tx_busy = 1'b0;
        Rst_n = 1'b1;
        ticks(60);
        total++; if (st_data.size() != 1) begin bad++; $display("FAIL no_start_after_reset: starts got %0d want 1", st_data.size()); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL flushed_after_reset: got %b want 1", fifo_empty); end
        $display("test_reset_mid: starts=%0d", st_data.size());
    endtask

    task automatic test_random();
        logic [7:0] expq[$];
        logic [2:0] sw;
        int nb;
        clear_log();
        resp_on = 1'b1;
        tx_busy = 1'b0;
        for (int it = 0; it < 8; it++) begin
            sw = 3'($urandom_range(0, 7));
            expq.push_back({5'b0, sw});
            resp_delay = $urandom_range(1, 6);
            resp_len = $urandom_range(1, 12);
            switches = sw;
            ticks(3);
            nb = $urandom_range(0, 6);
            for (int j = 0; j < nb; j++) begin
                send_btn = ~send_btn;
                ticks($urandom_range(1, N - 1));
            end
            send_btn = 1'b1;
            ticks(N + 8);
            nb = $urandom_range(0, 6);
            for (int j = 0; j < nb; j++) begin
                send_btn = ~send_btn;
                ticks($urandom_range(1, N - 1));
            end
            send_btn = 1'b0;
            ticks(N + 8);
            $display("random press %0d: switches=%0d bounces=%0d delay=%0d len=%0d", it, sw, nb, resp_delay, resp_len);
        end
        ticks(60);
        total++; if (st_data.size() != expq.size()) begin bad++; $display("FAIL random_count: got %0d want %0d", st_data.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < st_data.size(); i++) begin
            total++; if (st_data[i] !== expq[i]) begin bad++; $display("FAIL random_data[%0d]: got %h want %h", i, st_data[i], expq[i]); end
        end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL random_ack_err: got %b want 0", ack_err); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL random_overflow: got %b want 0", overflow_err); end
    endtask

    initial begin
        test_reset();
        test_single_send();
        test_debounce();
        test_overflow();
        test_ack_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
